alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one combinational ALU between two requesters, e.g. the execute stage and a branch/address-compare unit.
- Per cycle, picks one valid request and registers its operands and command into an issue stage that drives the ALU.
- Captures the ALU result and flags into a one-entry response buffer, tagged with the requester ID.
- Two-stage pipeline with valid/ready backpressure on both sides; sustains one operation per cycle when unstalled.

Parameters:
- WIDTH, 32, data width of operands and result; must match the shared ALU width.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_a, req0_b  input  WIDTH  requester 0 operands
- req0_cmd  input  3  requester 0 ALU command
- req1_valid, req1_ready, req1_a, req1_b, req1_cmd: same as requester 0, for requester 1
- alu_operandA, alu_operandB  output  WIDTH  to shared ALU, driven from issue registers
- alu_command  output  3  to shared ALU
- alu_result  input  WIDTH  from ALU, combinational
- alu_zero, alu_overflow, alu_carryout  input  1  ALU flags
- rsp_valid  output  1  response buffer holds a result
- rsp_ready  input  1  consumer takes the response
- rsp_id  output  1  requester that issued the response
- rsp_result  output  WIDTH  registered ALU result
- rsp_zero, rsp_overflow, rsp_carryout  output  1  registered flags

Behaviour:
- Reset: asynchronous on reset_n low.
  - s1_valid=0, s2_valid=0, last_grant=1, so requester 0 wins the first tie.
  - All issue and response data registers go to 0; alu_* outputs, rsp_* outputs and rsp_valid are 0.
- Reset mid-operation discards in-flight operations without producing a response.
- Stage 2 (response buffer):
  - s2_load = s1_valid && (!s2_valid || rsp_ready).
  - On s2_load, capture alu_result, the flags and the s1 ID; s2_valid=1.
  - If rsp_valid && rsp_ready && !s2_load, s2_valid clears to 0.
- Stage 1 (issue register):
  - s1_free = !s1_valid || s2_load.
  - alu_* outputs always equal the s1 registers, including while stalled.
- Arbitration, combinational, each cycle:
  - Only one request valid: that requester wins.
  - Both valid: the requester other than last_grant wins (round-robin).
  - reqN_ready = winner==N && s1_free; at most one ready high per cycle.
  - On acceptance: s1 loads that requester's a/b/cmd/ID, s1_valid=1, last_grant=N.
  - If s1_free && no request: s1_valid=0 when s2_load, otherwise it holds.
- Latency: request accepted at edge E, result visible on rsp_* after edge E+1, i.e. 2 cycles valid-to-response when unstalled.
- Throughput: one operation per cycle with rsp_ready held high.
- Backpressure:
  - rsp_valid high with rsp_ready low: rsp_* held stable, s2 cannot load, s1 holds, both reqN_ready low once s1 is full.
  - At most 2 operations in flight.
- Requester rules:
  - A requester must hold valid and data stable until its ready is seen.
  - Arbitration is re-evaluated every cycle, so a losing requester is not locked out.
- Ordering: responses leave in acceptance order; the ID distinguishes the requesters.
- Flags are passed through as produced by the ALU; the arbiter does not interpret commands.

Optional Feature:
- Macro ALU_ARB_FIXED_PRI_EN.
- Defined: fixed priority; requester 0 always wins when both are valid; last_grant is not implemented and has no effect.
- Undefined: round-robin as described in Behaviour.
- Latency, backpressure and reset behaviour are identical either way.

Test Plan:
- Single op: req0 ADD(000) a=5 b=7, rsp_ready=1 -> req0_ready same cycle; 2 cycles later rsp_valid=1, rsp_result=12, rsp_id=0, carryout=0, overflow=0.
- Contention: req0 and req1 both held valid for 4 ops, rsp_ready=1 -> accepts alternate 0,1,0,1 (fixed-pri build: 0,0,0,0 with req1 starved); one response per cycle in acceptance order.
- Flags: req1 SUB(001) a=3 b=3 -> rsp_result=0, rsp_zero=1, rsp_id=1; req0 ADD a=0x7FFFFFFF b=1 -> result 0x80000000, rsp_overflow=1.
- Backpressure: rsp_ready=0 for 5 cycles with 3 ops offered -> rsp_* stable at the first result, exactly 2 accepted, reqN_ready low; release gives results 1,2 then the third accepted.
- Reset mid-flight: assert reset_n=0 asynchronously with s1 and s2 full -> rsp_valid=0 and alu_* outputs 0 immediately; after release, req0 and req1 tie -> requester 0 granted first.

Source files
------------

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter_if
// Brief    : Requester, shared-ALU and response signals of alu_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [2:0]       req0_cmd;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [2:0]       req1_cmd;

  logic [WIDTH-1:0] alu_operandA;
  logic [WIDTH-1:0] alu_operandB;
  logic [2:0]       alu_command;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             alu_overflow;
  logic             alu_carryout;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic             rsp_overflow;
  logic             rsp_carryout;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cmd,
    input  req1_valid, req1_a, req1_b, req1_cmd,
    input  alu_result, alu_zero, alu_overflow, alu_carryout,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output alu_operandA, alu_operandB, alu_command,
    output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_overflow, rsp_carryout
  );

  // Environment side: requesters, ALU and response consumer
  modport master (
    output req0_valid, req0_a, req0_b, req0_cmd,
    output req1_valid, req1_a, req1_b, req1_cmd,
    output alu_result, alu_zero, alu_overflow, alu_carryout,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_operandA, alu_operandB, alu_command,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_overflow, rsp_carryout
  );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Brief    : Two-requester arbiter in front of a shared combinational ALU,
//            with an issue register and a one-entry tagged response buffer.
//            ALU_ARB_FIXED_PRI_EN: requester 0 always wins ties.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          reset_n,
  alu_arbiter_if.slave bus
);
  logic             r_s1_valid;
  logic             r_s1_id;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [2:0]       r_s1_cmd;

  logic             r_s2_valid;
  logic             r_s2_id;
  logic [WIDTH-1:0] r_s2_result;
  logic             r_s2_zero;
  logic             r_s2_overflow;
  logic             r_s2_carryout;

  logic w_s2_load;
  logic w_s1_free;
  logic w_grant1;
  logic w_accept0;
  logic w_accept1;
  logic w_accept;

  assign w_s2_load = r_s1_valid && (!r_s2_valid || bus.rsp_ready);
  assign w_s1_free = !r_s1_valid || w_s2_load;

`ifdef ALU_ARB_FIXED_PRI_EN
  assign w_grant1 = bus.req1_valid && !bus.req0_valid;
`else
  logic r_last_grant;

  // On a tie the requester that did not win last time goes next
  assign w_grant1 = bus.req1_valid && (!bus.req0_valid || !r_last_grant);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= 1'b1;
    end else if (w_accept) begin
      r_last_grant <= w_accept1;
    end
  end
`endif

  assign w_accept0 = bus.req0_valid && !w_grant1 && w_s1_free;
  assign w_accept1 = w_grant1 && w_s1_free;
  assign w_accept  = w_accept0 || w_accept1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_id    <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_cmd   <= 3'd0;
    end else begin
      if (w_s1_free) begin
        r_s1_valid <= w_accept;
      end
      if (w_accept) begin
        r_s1_id  <= w_accept1;
        r_s1_a   <= w_accept1 ? bus.req1_a   : bus.req0_a;
        r_s1_b   <= w_accept1 ? bus.req1_b   : bus.req0_b;
        r_s1_cmd <= w_accept1 ? bus.req1_cmd : bus.req0_cmd;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_valid    <= 1'b0;
      r_s2_id       <= 1'b0;
      r_s2_result   <= '0;
      r_s2_zero     <= 1'b0;
      r_s2_overflow <= 1'b0;
      r_s2_carryout <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid    <= 1'b1;
      r_s2_id       <= r_s1_id;
      r_s2_result   <= bus.alu_result;
      r_s2_zero     <= bus.alu_zero;
      r_s2_overflow <= bus.alu_overflow;
      r_s2_carryout <= bus.alu_carryout;
    end else if (r_s2_valid && bus.rsp_ready) begin
      r_s2_valid <= 1'b0;
    end
  end

  assign bus.req0_ready   = w_accept0;
  assign bus.req1_ready   = w_accept1;

  assign bus.alu_operandA = r_s1_a;
  assign bus.alu_operandB = r_s1_b;
  assign bus.alu_command  = r_s1_cmd;

  assign bus.rsp_valid    = r_s2_valid;
  assign bus.rsp_id       = r_s2_id;
  assign bus.rsp_result   = r_s2_result;
  assign bus.rsp_zero     = r_s2_zero;
  assign bus.rsp_overflow = r_s2_overflow;
  assign bus.rsp_carryout = r_s2_carryout;
endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Brief    : Directed and random checks of alu_arbiter against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
  localparam int WIDTH = 32;

  typedef struct packed {
    logic             id;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       cmd;
  } op_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  alu_arbiter_if #(.WIDTH(WIDTH)) bus();

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Shared ALU: returns {carryout, overflow, zero, result}
  function automatic logic [WIDTH+2:0] alu_fn(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [2:0] cmd);
    logic [WIDTH:0]   s;
    logic [WIDTH-1:0] r;
    logic             c;
    logic             v;
    s = '0;
    c = 1'b0;
    v = 1'b0;
    case (cmd)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[WIDTH-1:0];
        c = s[WIDTH];
        v = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      3'd1: begin
        s = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        r = s[WIDTH-1:0];
        c = s[WIDTH];
        v = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd4:    r = a ^ b;
      3'd5:    r = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
      default: r = a;
    endcase
    return {c, v, (r == '0), r};
  endfunction

  assign {bus.alu_carryout, bus.alu_overflow, bus.alu_zero, bus.alu_result} =
      alu_fn(bus.alu_operandA, bus.alu_operandB, bus.alu_command);

  // Reference model: pending requests per requester, issue slot, response slot
  op_t  rq0[$];
  op_t  rq1[$];
  op_t  issue_q[$];
  op_t  resp_q[$];
  bit   last_grant = 1'b1;
  bit   rsp_rdy    = 1'b1;
  int   dut_log[$];

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.rsp_ready  = rsp_rdy;
    bus.req0_valid = (rq0.size() > 0);
    bus.req0_a     = (rq0.size() > 0) ? rq0[0].a   : '0;
    bus.req0_b     = (rq0.size() > 0) ? rq0[0].b   : '0;
    bus.req0_cmd   = (rq0.size() > 0) ? rq0[0].cmd : 3'd0;
    bus.req1_valid = (rq1.size() > 0);
    bus.req1_a     = (rq1.size() > 0) ? rq1[0].a   : '0;
    bus.req1_b     = (rq1.size() > 0) ? rq1[0].b   : '0;
    bus.req1_cmd   = (rq1.size() > 0) ? rq1[0].cmd : 3'd0;
  endtask

  task automatic push(input logic id, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input logic [2:0] cmd);
    op_t o;
    o = '{id: id, a: a, b: b, cmd: cmd};
    if (id) rq1.push_back(o);
    else    rq0.push_back(o);
    drive();
  endtask

  // One clock: check outputs mid-cycle, advance the model, drive next inputs
  task automatic step();
    logic [WIDTH+2:0] e;
    bit has_rsp, load, free, v0, v1;
    int win;
    @(negedge clk);
    if (bus.req0_ready === 1'b1) dut_log.push_back(0);
    if (bus.req1_ready === 1'b1) dut_log.push_back(1);

    has_rsp = (resp_q.size() > 0);
    check("rsp_valid", bus.rsp_valid, has_rsp);
    if (has_rsp) begin
      e = alu_fn(resp_q[0].a, resp_q[0].b, resp_q[0].cmd);
      check("rsp_id", bus.rsp_id, resp_q[0].id);
      check("rsp_result", bus.rsp_result, e[WIDTH-1:0]);
      check("rsp_flags", {bus.rsp_carryout, bus.rsp_overflow, bus.rsp_zero},
            e[WIDTH+2:WIDTH]);
    end
    if (issue_q.size() > 0) begin
      check("alu_operandA", bus.alu_operandA, issue_q[0].a);
      check("alu_operandB", bus.alu_operandB, issue_q[0].b);
      check("alu_command", bus.alu_command, issue_q[0].cmd);
    end

    load = (issue_q.size() > 0) && (!has_rsp || rsp_rdy);
    free = (issue_q.size() == 0) || load;
    v0   = (rq0.size() > 0);
    v1   = (rq1.size() > 0);
    win  = -1;
`ifdef ALU_ARB_FIXED_PRI_EN
    if (v0)      win = 0;
    else if (v1) win = 1;
`else
    if (v0 && v1) win = last_grant ? 0 : 1;
    else if (v0)  win = 0;
    else if (v1)  win = 1;
`endif
    if (!free) win = -1;
    check("req0_ready", bus.req0_ready, (win == 0));
    check("req1_ready", bus.req1_ready, (win == 1));

    if (has_rsp && rsp_rdy) void'(resp_q.pop_front());
    if (load) resp_q.push_back(issue_q.pop_front());
    if (win == 0) begin
      issue_q.push_back(rq0.pop_front());
      last_grant = 1'b0;
    end else if (win == 1) begin
      issue_q.push_back(rq1.pop_front());
      last_grant = 1'b1;
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic drain();
    bit busy;
    rsp_rdy = 1'b1;
    drive();
    for (int i = 0; i < 40; i++) begin
      busy = (rq0.size() + rq1.size() + issue_q.size() + resp_q.size()) != 0;
      if (busy) step();
    end
    busy = (rq0.size() + rq1.size() + issue_q.size() + resp_q.size()) != 0;
    check("drain_timeout", busy, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order[4];
    logic [1:0] got;

    drive();
    #1;
    check("reset_rsp_valid", bus.rsp_valid, 1'b0);
    check("reset_rsp_result", bus.rsp_result, '0);
    check("reset_alu_operandA", bus.alu_operandA, '0);
    check("reset_alu_command", bus.alu_command, '0);
    #11 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Contention from reset: tie winners alternate starting with requester 0
    dut_log.delete();
    for (int i = 0; i < 4; i++) begin
      push(1'b0, WIDTH'(i + 1), WIDTH'(100), 3'd0);
      push(1'b1, WIDTH'(i + 50), WIDTH'(7), 3'd1);
    end
`ifdef ALU_ARB_FIXED_PRI_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 1, 0, 1};
`endif
    for (int i = 0; i < 10; i++) step();
    check("contention_count", WIDTH'(dut_log.size()), WIDTH'(8));
    for (int i = 0; i < 4; i++)
      if (dut_log.size() > i) check("contention_order", WIDTH'(dut_log[i]), WIDTH'(exp_order[i]));
    drain();

    // Single op: 5 + 7
    push(1'b0, 32'd5, 32'd7, 3'd0);
    step();
    step();
    check("single_valid", bus.rsp_valid, 1'b1);
    check("single_result", bus.rsp_result, 32'd12);
    check("single_id", bus.rsp_id, 1'b0);
    check("single_co_ov", {bus.rsp_carryout, bus.rsp_overflow}, 2'b00);
    drain();

    // Flags
    push(1'b1, 32'd3, 32'd3, 3'd1);
    step();
    step();
    check("sub_result", bus.rsp_result, 32'd0);
    check("sub_zero", bus.rsp_zero, 1'b1);
    check("sub_id", bus.rsp_id, 1'b1);
    drain();
    push(1'b0, 32'h7FFF_FFFF, 32'd1, 3'd0);
    step();
    step();
    check("ovf_result", bus.rsp_result, 32'h8000_0000);
    check("ovf_flag", bus.rsp_overflow, 1'b1);
    drain();

    // Backpressure: three ops offered while the consumer stalls
    rsp_rdy = 1'b0;
    drive();
    dut_log.delete();
    push(1'b0, 32'd10, 32'd20, 3'd0);
    push(1'b0, 32'd100, 32'd1, 3'd1);
    push(1'b0, 32'd7, 32'd8, 3'd4);
    for (int i = 0; i < 5; i++) begin
      step();
      if (i >= 1) begin
        check("bp_rsp_held", bus.rsp_result, 32'd30);
        check("bp_ready_low", {bus.req0_ready, bus.req1_ready}, 2'b00);
      end
    end
    check("bp_accepted", WIDTH'(dut_log.size()), WIDTH'(2));
    rsp_rdy = 1'b1;
    drive();
    step();
    check("bp_second", bus.rsp_result, 32'd99);
    step();
    check("bp_third", bus.rsp_result, 32'd15);
    check("bp_accepted_all", WIDTH'(dut_log.size()), WIDTH'(3));
    drain();

    // Random traffic with random consumer stalls
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0 && rq0.size() < 3)
        push(1'b0, $urandom, $urandom, 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 2) == 0 && rq1.size() < 3)
        push(1'b1, $urandom, $urandom, 3'($urandom_range(0, 7)));
      rsp_rdy = ($urandom_range(0, 3) != 0);
      drive();
      step();
    end
    drain();

    // Reset with both stages full
    rsp_rdy = 1'b0;
    drive();
    push(1'b0, 32'd11, 32'd22, 3'd0);
    push(1'b1, 32'd33, 32'd44, 3'd1);
    step();
    step();
    #2 reset_n = 1'b0;
    #1;
    check("midrst_rsp_valid", bus.rsp_valid, 1'b0);
    check("midrst_rsp_result", bus.rsp_result, '0);
    check("midrst_alu_operandA", bus.alu_operandA, '0);
    check("midrst_alu_operandB", bus.alu_operandB, '0);
    check("midrst_alu_command", bus.alu_command, '0);
    rq0.delete();
    rq1.delete();
    issue_q.delete();
    resp_q.delete();
    last_grant = 1'b1;
    drive();
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;
    rsp_rdy = 1'b1;
    dut_log.delete();
    push(1'b0, 32'd1, 32'd1, 3'd0);
    push(1'b1, 32'd2, 32'd2, 3'd0);
    step();
    got = (dut_log.size() == 1) ? 2'(dut_log[0]) : 2'b11;
    check("midrst_first_grant", got, 2'b00);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
